// File: rtl/sdp_ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed synchronous FIFO.
package sdp_ram_fifo_pkg;

  typedef enum logic {
    Standard,
    Fwft
  } fifo_mode_e;

  // Occupancy counter needs one extra bit to represent a completely full FIFO.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sdp_ram_fifo_if.sv
// FIFO write/read handshake bundle; master is the FIFO user, slave is the FIFO.
interface sdp_ram_fifo_if
  import sdp_ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);

  localparam int unsigned CountWidth = count_width(ADDR_WIDTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  overflow;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  empty;
  logic                  almost_empty;
  logic                  underflow;
  logic [CountWidth-1:0] count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, overflow, rd_data, rd_data_valid, empty, almost_empty,
           underflow, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, overflow, rd_data, rd_data_valid, empty, almost_empty,
           underflow, count
  );

endinterface

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module simple_dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       RAM_TYPE   = "block"
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid
);

  if (RAM_TYPE != "block" && RAM_TYPE != "distributed") begin : g_bad_ram_type
    $error("simple_dual_port_ram: RAM_TYPE must be \"block\" or \"distributed\"");
  end

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/sdp_ram_fifo.sv
// Synchronous FIFO over a simple dual-port RAM, standard or first-word-fall-through read.
module sdp_ram_fifo
  import sdp_ram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter string       RAM_TYPE   = "block",
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input logic           clk,
  input logic           rst_n,
  sdp_ram_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = count_width(ADDR_WIDTH);
  localparam fifo_mode_e  MODE  = (FWFT != 0) ? Fwft : Standard;

  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("sdp_ram_fifo: ADDR_WIDTH must be at least 1");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sdp_ram_fifo: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("sdp_ram_fifo: AF_LEVEL must not exceed DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, almost_full_q, almost_empty_q;
  logic                  overflow_q, underflow_q;
  logic                  head_hold_q, head_hold_d;
  logic                  wr_accept, pop, fetch, rd_reject, head_valid;
  logic                  ram_rd_valid;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // In FWFT mode the RAM output register is the head slot: a word is there either in the
  // cycle right after its fetch (ram_rd_valid) or while it waits to be popped (head_hold_q).
  always_comb begin
    wr_accept  = bus.wr_en & ~full_q;
    head_valid = ram_rd_valid | head_hold_q;
    pop        = 1'b0;
    rd_reject  = 1'b0;
    fetch      = 1'b0;
    if (MODE == Fwft) begin
      pop       = bus.rd_en & head_valid;
      rd_reject = bus.rd_en & ~head_valid;
      // RAM holds count minus the head word; only words written in earlier cycles count.
      fetch     = (count_q != CW'(head_valid)) & (~head_valid | pop);
    end else begin
      pop       = bus.rd_en & ~empty_q;
      rd_reject = bus.rd_en & empty_q;
      fetch     = pop;
    end
    head_hold_d = (MODE == Fwft) & head_valid & ~pop & ~fetch;

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_LEVEL == 0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      head_hold_q    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (fetch)     rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q        <= count_d;
      full_q         <= (count_d == DepthCnt);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AfCnt);
      almost_empty_q <= (count_d <= AeCnt);
      overflow_q     <= bus.wr_en & full_q;
      underflow_q    <= rd_reject;
      head_hold_q    <= head_hold_d;
    end
  end

  simple_dual_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_TYPE   (RAM_TYPE)
  ) u_ram (
    .wr_clk        (clk),
    .wr_en         (wr_accept),
    .wr_addr       (wr_ptr_q),
    .wr_data       (bus.wr_data),
    .rd_clk        (clk),
    .rst_n         (rst_n),
    .rd_en         (fetch),
    .rd_addr       (rd_ptr_q),
    .rd_data       (ram_rd_data),
    .rd_data_valid (ram_rd_valid)
  );

  assign bus.rd_data       = ram_rd_data;
  assign bus.rd_data_valid = (MODE == Fwft) ? head_valid : ram_rd_valid;
  assign bus.empty         = (MODE == Fwft) ? ~head_valid : empty_q;
  assign bus.full          = full_q;
  assign bus.almost_full   = almost_full_q;
  assign bus.almost_empty  = almost_empty_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
  assign bus.count         = count_q;

endmodule

// File: tb/tb_sdp_ram_fifo.sv
// Directed bench for sdp_ram_fifo in standard and FWFT modes with a queue scoreboard.
module tb_sdp_ram_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];

  always #5 clk = ~clk;

  sdp_ram_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) sif ();
  sdp_ram_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) fif ();

  sdp_ram_fifo #(
    .DATA_WIDTH (8), .ADDR_WIDTH (4), .RAM_TYPE ("block"),
    .FWFT (0), .AF_LEVEL (14), .AE_LEVEL (2)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  sdp_ram_fifo #(
    .DATA_WIDTH (8), .ADDR_WIDTH (4), .RAM_TYPE ("distributed"),
    .FWFT (1), .AF_LEVEL (14), .AE_LEVEL (2)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s_op(input logic we, input logic [7:0] wd, input logic re);
    sif.wr_en = we; sif.wr_data = wd; sif.rd_en = re;
    tick();
  endtask

  task automatic f_op(input logic we, input logic [7:0] wd, input logic re);
    fif.wr_en = we; fif.wr_data = wd; fif.rd_en = re;
    tick();
  endtask

  // Monitor: standard mode delivers on rd_data_valid, FWFT delivers on a pop.
  always @(negedge clk) begin
    if (rst_n && sif.rd_data_valid) begin
      if (exp_s.size() == 0) check("std_unexpected_valid", 32'(sif.rd_data_valid), 0);
      else check("std_rd_data", 32'(sif.rd_data), 32'(exp_s.pop_front()));
    end
    if (rst_n && fif.rd_data_valid && fif.rd_en) begin
      if (exp_f.size() == 0) check("fwft_unexpected_pop", 32'(fif.rd_en), 0);
      else check("fwft_rd_data", 32'(fif.rd_data), 32'(exp_f.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    sif.wr_en = 1'b0; sif.wr_data = '0; sif.rd_en = 1'b0;
    fif.wr_en = 1'b0; fif.wr_data = '0; fif.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_std_count", 32'(sif.count), 0);
    check("rst_std_empty", 32'(sif.empty), 1);
    check("rst_std_ae", 32'(sif.almost_empty), 1);
    check("rst_std_full", 32'(sif.full), 0);
    check("rst_std_af", 32'(sif.almost_full), 0);
    check("rst_std_valid", 32'(sif.rd_data_valid), 0);
    check("rst_std_rd_data", 32'(sif.rd_data), 0);
    check("rst_fwft_empty", 32'(fif.empty), 1);
    check("rst_fwft_valid", 32'(fif.rd_data_valid), 0);
    rst_n = 1'b1;
    tick();

    // Fill to full, reject one write, drain in order.
    for (int i = 0; i < 16; i++) begin
      exp_s.push_back(8'(i));
      s_op(1'b1, 8'(i), 1'b0);
      if (i == 1)  check("std_ae_at_2", 32'(sif.almost_empty), 1);
      if (i == 2)  check("std_ae_at_3", 32'(sif.almost_empty), 0);
      if (i == 12) check("std_af_at_13", 32'(sif.almost_full), 0);
      if (i == 13) check("std_af_at_14", 32'(sif.almost_full), 1);
    end
    check("std_full_16", 32'(sif.full), 1);
    check("std_count_16", 32'(sif.count), 16);
    check("std_no_early_ovf", 32'(sif.overflow), 0);
    s_op(1'b1, 8'hAA, 1'b0);
    check("std_overflow", 32'(sif.overflow), 1);
    check("std_count_after_ovf", 32'(sif.count), 16);
    s_op(1'b0, 8'h00, 1'b0);
    check("std_overflow_pulse", 32'(sif.overflow), 0);
    for (int i = 0; i < 16; i++) begin
      s_op(1'b0, 8'h00, 1'b1);
      check("std_valid_latency", 32'(sif.rd_data_valid), 1);
    end
    s_op(1'b0, 8'h00, 1'b0);
    check("std_valid_one_cycle", 32'(sif.rd_data_valid), 0);
    check("std_empty_drained", 32'(sif.empty), 1);
    check("std_count_drained", 32'(sif.count), 0);

    // Read of empty FIFO together with a write.
    exp_s.push_back(8'h5A);
    s_op(1'b1, 8'h5A, 1'b1);
    check("std_underflow", 32'(sif.underflow), 1);
    check("std_count_uf", 32'(sif.count), 1);
    check("std_no_valid_uf", 32'(sif.rd_data_valid), 0);
    s_op(1'b0, 8'h00, 1'b1);
    check("std_valid_5a", 32'(sif.rd_data_valid), 1);
    check("std_underflow_pulse", 32'(sif.underflow), 0);
    s_op(1'b0, 8'h00, 1'b0);
    check("std_rd_data_hold", 32'(sif.rd_data), 32'h5A);

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < 16; i++) begin
      exp_s.push_back(8'(8'h10 + i));
      s_op(1'b1, 8'(8'h10 + i), 1'b0);
    end
    s_op(1'b1, 8'hEE, 1'b1);
    check("std_full_rw_ovf", 32'(sif.overflow), 1);
    check("std_full_rw_count", 32'(sif.count), 15);
    check("std_full_rw_valid", 32'(sif.rd_data_valid), 1);
    for (int i = 0; i < 15; i++) s_op(1'b0, 8'h00, 1'b1);
    s_op(1'b0, 8'h00, 1'b0);
    check("std_full_rw_drained", 32'(sif.count), 0);

    // Pointer wrap with interleaved traffic and level flags.
    for (int i = 0; i < 14; i++) begin
      exp_s.push_back(8'(8'h80 + i));
      s_op(1'b1, 8'(8'h80 + i), 1'b0);
      if (i == 12) check("wrap_af_at_13", 32'(sif.almost_full), 0);
      if (i == 13) check("wrap_af_at_14", 32'(sif.almost_full), 1);
    end
    for (int i = 0; i < 40; i++) begin
      exp_s.push_back(8'(8'h40 + i));
      s_op(1'b1, 8'(8'h40 + i), 1'b1);
    end
    check("wrap_count_14", 32'(sif.count), 14);
    for (int k = 1; k <= 14; k++) begin
      s_op(1'b0, 8'h00, 1'b1);
      if (k == 1)  check("wrap_af_fall_13", 32'(sif.almost_full), 0);
      if (k == 11) check("wrap_ae_at_3", 32'(sif.almost_empty), 0);
      if (k == 12) check("wrap_ae_at_2", 32'(sif.almost_empty), 1);
    end
    s_op(1'b0, 8'h00, 1'b0);
    check("wrap_empty", 32'(sif.empty), 1);

    // FWFT: rejected pop on empty.
    f_op(1'b0, 8'h00, 1'b1);
    check("fwft_underflow", 32'(fif.underflow), 1);
    f_op(1'b0, 8'h00, 1'b0);
    check("fwft_underflow_pulse", 32'(fif.underflow), 0);

    // FWFT: first word appears two cycles after its write, then gapless stream.
    exp_f.push_back(8'h33);
    f_op(1'b1, 8'h33, 1'b0);
    check("fwft_not_early", 32'(fif.rd_data_valid), 0);
    check("fwft_count_1", 32'(fif.count), 1);
    f_op(1'b0, 8'h00, 1'b0);
    check("fwft_valid_33", 32'(fif.rd_data_valid), 1);
    check("fwft_data_33", 32'(fif.rd_data), 32'h33);
    check("fwft_not_empty", 32'(fif.empty), 0);
    exp_f.push_back(8'h34);
    f_op(1'b1, 8'h34, 1'b0);
    exp_f.push_back(8'h35);
    f_op(1'b1, 8'h35, 1'b0);
    for (int k = 0; k < 13; k++) begin
      fif.rd_en   = 1'b1;
      fif.wr_en   = (k < 10);
      fif.wr_data = 8'(8'h36 + k);
      if (k < 10) exp_f.push_back(8'(8'h36 + k));
      check("fwft_stream_valid", 32'(fif.rd_data_valid), 1);
      tick();
    end
    fif.rd_en = 1'b0; fif.wr_en = 1'b0;
    check("fwft_stream_end_valid", 32'(fif.rd_data_valid), 0);
    check("fwft_stream_end_count", 32'(fif.count), 0);
    tick();

    // FWFT: asynchronous reset with words stored.
    for (int i = 0; i < 9; i++) begin
      exp_f.push_back(8'(8'h90 + i));
      f_op(1'b1, 8'(8'h90 + i), 1'b0);
    end
    f_op(1'b0, 8'h00, 1'b0);
    f_op(1'b0, 8'h00, 1'b0);
    check("fwft_count_9", 32'(fif.count), 9);
    check("fwft_head_90", 32'(fif.rd_data), 32'h90);
    #2 rst_n = 1'b0;
    #1;
    exp_f.delete();
    check("arst_count", 32'(fif.count), 0);
    check("arst_empty", 32'(fif.empty), 1);
    check("arst_ae", 32'(fif.almost_empty), 1);
    check("arst_af", 32'(fif.almost_full), 0);
    check("arst_full", 32'(fif.full), 0);
    check("arst_valid", 32'(fif.rd_data_valid), 0);
    check("arst_rd_data", 32'(fif.rd_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("arst_valid_after", 32'(fif.rd_data_valid), 0);
    exp_f.push_back(8'h77);
    f_op(1'b1, 8'h77, 1'b0);
    f_op(1'b0, 8'h00, 1'b0);
    check("arst_valid_77", 32'(fif.rd_data_valid), 1);
    check("arst_data_77", 32'(fif.rd_data), 32'h77);
    f_op(1'b0, 8'h00, 1'b1);
    fif.rd_en = 1'b0;
    check("arst_empty_after_pop", 32'(fif.empty), 1);

    tick();
    check("std_scoreboard_drained", exp_s.size(), 0);
    check("fwft_scoreboard_drained", exp_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
